// File: rtl/sprite_frame_blitter.sv
// sprite_frame_blitter
//   Frame compositor for the VGA path. A frame request fills the screen with a
//   background colour, then draws N_SPR colour-keyed sprites one pixel per clock
//   from a shared sprite ROM. Outputs drive vga_adapter x/y/colour/plot directly.
//   Optional build macro: SPRITE_BLIT_CLIP_EN (suppress plots off the right or
//   bottom screen edge; without it, coordinates wrap modulo 2^XW / 2^YW).
// Ports
//   CLOCK_50, resetn        clock, async active-low reset
//   frame_tick              start-frame pulse (ignored while busy)
//   bg_colour               background fill colour
//   spr_en/id/x/y           per-channel sprite state, channel i in slice i
//   rom_addr / rom_data     {id,row,col} to sprite ROM, data one cycle later
//   x, y, colour, plot      pixel write to vga_adapter
//   busy, frame_done        frame in progress / last-pixel pulse
module sprite_frame_blitter #(
  parameter int N_SPR = 6,
  parameter int ID_W  = 4,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int CW    = 12,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int SCR_W = 320,
  parameter int SCR_H = 240,
  parameter logic [CW-1:0] KEY = 12'hFFF
) (
  input  logic                                  CLOCK_50,
  input  logic                                  resetn,
  input  logic                                  frame_tick,
  input  logic [CW-1:0]                         bg_colour,
  input  logic [N_SPR-1:0]                      spr_en,
  input  logic [N_SPR*ID_W-1:0]                 spr_id,
  input  logic [N_SPR*XW-1:0]                   spr_x,
  input  logic [N_SPR*YW-1:0]                   spr_y,
  output logic [ID_W+$clog2(SPR_W*SPR_H)-1:0]   rom_addr,
  input  logic [CW-1:0]                         rom_data,
  output logic [XW-1:0]                         x,
  output logic [YW-1:0]                         y,
  output logic [CW-1:0]                         colour,
  output logic                                  plot,
  output logic                                  busy,
  output logic                                  frame_done
);
  localparam int CB  = $clog2(SPR_W);
  localparam int PB  = $clog2(SPR_W*SPR_H);
  localparam int CHW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam logic [XW-1:0]  XMAX = XW'(SCR_W-1);
  localparam logic [YW-1:0]  YMAX = YW'(SCR_H-1);
  localparam logic [CHW-1:0] LAST = CHW'(N_SPR-1);

  typedef enum logic [2:0] {IDLE, BG, SETUP, DRAW, FLUSH, DONE} state_t;

  state_t state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [PB-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  bx_q, bx_d;
  logic [YW-1:0]  by_q, by_d;

  // frame snapshot, so inputs changing mid-frame have no effect
  logic [CW-1:0]         bg_q;
  logic [N_SPR-1:0]      en_q;
  logic [N_SPR*ID_W-1:0] id_q;
  logic [N_SPR*XW-1:0]   sx_q;
  logic [N_SPR*YW-1:0]   sy_q;

  // pixel pipeline stage aligned with the ROM read latency
  logic [XW:0] px_q;
  logic [YW:0] py_q;
  logic        pv_q;

  logic            snap;
  logic [ID_W-1:0] cur_id;
  logic [XW-1:0]   cur_sx;
  logic [YW-1:0]   cur_sy;
  logic [XW:0]     xsum;
  logic [YW:0]     ysum;
  logic            clip;

  assign snap   = (state_q == IDLE) && frame_tick;
  assign cur_id = id_q[ch_q*ID_W +: ID_W];
  assign cur_sx = sx_q[ch_q*XW +: XW];
  assign cur_sy = sy_q[ch_q*YW +: YW];
  // carry bit kept so the clip test sees sums past the coordinate width
  assign xsum   = {1'b0, cur_sx} + (XW+1)'(cnt_q[CB-1:0]);
  assign ysum   = {1'b0, cur_sy} + (YW+1)'(cnt_q[PB-1:CB]);

`ifdef SPRITE_BLIT_CLIP_EN
  assign clip = (px_q >= (XW+1)'(SCR_W)) || (py_q >= (YW+1)'(SCR_H));
`else
  assign clip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    unique case (state_q)
      IDLE: if (frame_tick) begin
        state_d = BG;
        bx_d    = '0;
        by_d    = '0;
      end
      BG: begin
        if (bx_q == XMAX) begin
          bx_d = '0;
          if (by_q == YMAX) begin
            state_d = SETUP;
            ch_d    = '0;
          end else begin
            by_d = by_q + YW'(1);
          end
        end else begin
          bx_d = bx_q + XW'(1);
        end
      end
      SETUP: begin
        if (en_q[ch_q]) begin
          state_d = DRAW;
          cnt_d   = '0;
        end else if (ch_q == LAST) begin
          state_d = DONE;
        end else begin
          ch_d = ch_q + CHW'(1);
        end
      end
      DRAW: begin
        cnt_d = cnt_q + PB'(1);
        if (cnt_q == '1) state_d = FLUSH;
      end
      // the last sprite goes straight to DONE, no extra SETUP cycle
      FLUSH: begin
        if (ch_q == LAST) begin
          state_d = DONE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = SETUP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bg_q    <= '0;
      en_q    <= '0;
      id_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      if (snap) begin
        bg_q <= bg_colour;
        en_q <= spr_en;
        id_q <= spr_id;
        sx_q <= spr_x;
        sy_q <= spr_y;
      end
      pv_q <= (state_q == DRAW);
      if (state_q == DRAW) begin
        px_q <= xsum;
        py_q <= ysum;
      end
    end
  end

  always_comb begin
    rom_addr   = (state_q == DRAW) ? {cur_id, cnt_q} : '0;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    if (state_q == BG) begin
      x      = bx_q;
      y      = by_q;
      colour = bg_q;
      plot   = 1'b1;
    end else begin
      x      = px_q[XW-1:0];
      y      = py_q[YW-1:0];
      colour = pv_q ? rom_data : '0;
      plot   = pv_q && (rom_data != KEY) && !clip;
    end
  end
endmodule
